// File: rtl/pc_fetch_control_if.sv
// Fetch-control bus between the IF-stage PC logic and its surroundings
// (PC adder, instruction memory, hazard unit, branch/jump resolution).
interface pc_fetch_control_if;
  logic [31:0] PCAddResult;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        JumpReg;
  logic [31:0] JRTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Stall;
  logic        FetchReady;
  logic [31:0] PCResult;
  logic        FetchValid;
  logic        Flush;
  logic        AlignFault;
  logic [31:0] BadAddr;

  modport master (
    input  PCAddResult, BranchTaken, BranchTarget, JumpReg, JRTarget,
           Jump, JumpTarget, Stall, FetchReady,
    output PCResult, FetchValid, Flush, AlignFault, BadAddr
  );

  modport slave (
    output PCAddResult, BranchTaken, BranchTarget, JumpReg, JRTarget,
           Jump, JumpTarget, Stall, FetchReady,
    input  PCResult, FetchValid, Flush, AlignFault, BadAddr
  );
endinterface

// File: rtl/pc_fetch_control.sv
// IF-stage program counter: sequential advance, prioritised redirects,
// stall-deferred redirects and misaligned-target trapping.
module pc_fetch_control #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic                 Clk,
  input  logic                 Reset,
  pc_fetch_control_if.master   bus
);

  typedef enum logic [1:0] {BOOT, RUN, PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        flush_q, flush_d;
  logic        align_fault_q, align_fault_d;
  logic [31:0] bad_addr_q, bad_addr_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic        pend_vld_q, pend_vld_d;

  logic        redirect;
  logic [31:0] redirect_tgt;
  logic        load_en;
  logic [31:0] load_tgt;

  // Older instruction wins: EX branch over ID jr over ID j/jal.
  function automatic logic [31:0] select_target(
    input logic        bt,
    input logic [31:0] bt_tgt,
    input logic        jr,
    input logic [31:0] jr_tgt,
    input logic [31:0] j_tgt
  );
    if (bt)      return bt_tgt;
    else if (jr) return jr_tgt;
    else         return j_tgt;
  endfunction

  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  always_comb begin
    redirect     = bus.BranchTaken | bus.JumpReg | bus.Jump;
    redirect_tgt = select_target(bus.BranchTaken, bus.BranchTarget,
                                 bus.JumpReg, bus.JRTarget, bus.JumpTarget);
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    align_fault_d = 1'b0;
    bad_addr_d    = bad_addr_q;
    pend_tgt_d    = pend_tgt_q;
    pend_vld_d    = pend_vld_q;
    load_en       = 1'b0;
    load_tgt      = redirect_tgt;

    unique case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        if (redirect && !bus.Stall) begin
          load_en = 1'b1;
        end else if (redirect) begin
          pend_tgt_d = redirect_tgt;
          pend_vld_d = 1'b1;
          state_d    = PEND;
        end else if (fetch_valid_q && bus.FetchReady && !bus.Stall) begin
          pc_d = bus.PCAddResult;
        end
      end
      PEND: begin
        if (bus.Stall) begin
          if (redirect) pend_tgt_d = redirect_tgt;
        end else begin
          load_en    = 1'b1;
          load_tgt   = redirect ? redirect_tgt : pend_tgt_q;
          pend_vld_d = 1'b0;
          state_d    = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    // Alignment is only judged when a target actually enters the PC.
    if (load_en) begin
      flush_d = 1'b1;
      if (misaligned(load_tgt)) begin
        pc_d          = EXC_VECTOR;
        bad_addr_d    = load_tgt;
        align_fault_d = 1'b1;
      end else begin
        pc_d = load_tgt;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= BOOT;
      pc_q          <= RESET_VECTOR;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      align_fault_q <= 1'b0;
      bad_addr_q    <= 32'h0;
      pend_tgt_q    <= 32'h0;
      pend_vld_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      align_fault_q <= align_fault_d;
      bad_addr_q    <= bad_addr_d;
      pend_tgt_q    <= pend_tgt_d;
      pend_vld_q    <= pend_vld_d;
    end
  end

  assign bus.PCResult   = pc_q;
  assign bus.FetchValid = fetch_valid_q;
  assign bus.Flush      = flush_q;
  assign bus.AlignFault = align_fault_q;
  assign bus.BadAddr    = bad_addr_q;

endmodule
